// File: rtl/cmo_arbiter.sv
// cmo_arbiter: shares one L1D$ CMO port among NUM_REQ requesters; acks are steered back in acceptance order.
// Zero-cycle request/ack paths; stalls when MAX_OUTSTANDING are in flight; CMO_ARB_RR_EN selects round-robin over fixed priority.
package ariane_pkg;
   typedef enum logic [3:0] {
      CMO_CLEAN = 4'd0,
      CMO_FLUSH = 4'd1,
      CMO_INV   = 4'd2,
      CMO_ZERO  = 4'd3
   } cmo_t;

   typedef struct packed {
      logic        req;
      logic [3:0]  trans_id;
      logic [63:0] address;
      cmo_t        cmo_op;
   } cmo_req_t;

   typedef struct packed {
      logic       req_ready;
      logic       ack;
      logic [3:0] trans_id;
   } cmo_resp_t;
endpackage

module cmo_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  ariane_pkg::cmo_req_t  [NUM_REQ-1:0]        req_i,
   output ariane_pkg::cmo_resp_t [NUM_REQ-1:0]        resp_o,
   output ariane_pkg::cmo_req_t                       cmo_req_o,
   input  ariane_pkg::cmo_resp_t                      cmo_resp_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
   output logic                                       busy_o,
   output logic                                       err_o
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

   logic [IDX_W-1:0]   slots [MAX_OUTSTANDING];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               locked;
   logic [IDX_W-1:0]   lock_idx;
   logic               gnt_vld;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   head;
   logic [NUM_REQ-1:0] gnt;
   logic               full, empty, accept, pop, any_req, err;
`ifdef CMO_ARB_RR_EN
   logic [IDX_W-1:0]   prio;
`endif

   assign full  = (count == CNT_W'(MAX_OUTSTANDING));
   assign empty = (count == '0);
   assign head  = slots[rd_ptr];

   // A presented-but-stalled requester keeps the port until it is accepted or withdraws.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (locked && req_i[lock_idx].req) begin
         gnt_vld = 1'b1;
         gnt_idx = lock_idx;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CMO_ARB_RR_EN
            cand = IDX_W'((int'(prio) + k) % NUM_REQ);
`else
            cand = IDX_W'(k);
`endif
            if (!gnt_vld && req_i[cand].req) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
   end

   assign gnt = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;

   always_comb begin
      cmo_req_o = '0;
      if (gnt_vld) begin
         cmo_req_o     = req_i[gnt_idx];
         cmo_req_o.req = ~full;
      end
   end

   assign accept = cmo_req_o.req & cmo_resp_i.req_ready;
   assign pop    = cmo_resp_i.ack & ~empty;

   always_comb begin
      any_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         any_req                = any_req | req_i[i].req;
         resp_o[i].req_ready    = gnt[i] & ~full & cmo_resp_i.req_ready;
         resp_o[i].ack          = pop && (head == IDX_W'(i));
         resp_o[i].trans_id     = resp_o[i].ack ? cmo_resp_i.trans_id : '0;
      end
   end

   assign outstanding_o = count;
   assign busy_o        = any_req | (count != '0);
   assign err_o         = err;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         err      <= 1'b0;
         locked   <= 1'b0;
         lock_idx <= '0;
`ifdef CMO_ARB_RR_EN
         prio     <= '0;
`endif
      end else begin
         if (accept) begin
            slots[wr_ptr] <= gnt_idx;
            wr_ptr        <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(accept) - CNT_W'(pop);
         if (cmo_resp_i.ack && empty)
            err <= 1'b1;
         locked   <= cmo_req_o.req & ~cmo_resp_i.req_ready;
         lock_idx <= gnt_idx;
`ifdef CMO_ARB_RR_EN
         if (accept)
            prio <= IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
`endif
      end
   end
endmodule

// File: tb/tb_cmo_arbiter.sv
// tb_cmo_arbiter: directed scenarios then random traffic, checked every cycle against a queue-based model.
module tb_cmo_arbiter;
   import ariane_pkg::*;

   localparam int N  = 3;
   localparam int M  = 4;
   localparam int CW = $clog2(M+1);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   cmo_req_t  [N-1:0]    req;
   cmo_resp_t [N-1:0]    resp;
   cmo_req_t             cmo_req;
   cmo_resp_t            cmo_resp;
   logic [CW-1:0]        outst;
   logic                 busy, err;

   always #5 clk = ~clk;

   cmo_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(M)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .resp_o(resp),
      .cmo_req_o(cmo_req), .cmo_resp_i(cmo_resp),
      .outstanding_o(outst), .busy_o(busy), .err_o(err)
   );

   // Reference state: outstanding requester indices in acceptance order.
   int        q[$];
   int        rr = 0;
   int        lock_idx = -1;
   bit        merr = 1'b0;
   int        g;
   cmo_req_t  e_req;
   cmo_resp_t [N-1:0] e_resp;
   int        passed = 0;
   int        total = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic predict();
      bit any;
      g = -1;
      e_req = '0;
      e_resp = '0;
      if (lock_idx >= 0 && req[lock_idx].req) g = lock_idx;
      else
         for (int k = 0; k < N; k++)
            if (g < 0 && req[(rr + k) % N].req) g = (rr + k) % N;
      if (g >= 0) begin
         e_req = req[g];
         e_req.req = (q.size() < M);
         e_resp[g].req_ready = (q.size() < M) && cmo_resp.req_ready;
      end
      if (cmo_resp.ack && q.size() > 0) begin
         e_resp[q[0]].ack = 1'b1;
         e_resp[q[0]].trans_id = cmo_resp.trans_id;
      end
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= req[i].req;
      chk("cmo_req", 128'(cmo_req), 128'(e_req));
      chk("resp", 128'(resp), 128'(e_resp));
      chk("outstanding", 128'(outst), 128'(q.size()));
      chk("busy", 128'(busy), 128'(any || q.size() != 0));
      chk("err", 128'(err), 128'(merr));
   endtask

   task automatic settle();
      #3;
      if (rst_n) predict();
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         rr = 0;
         lock_idx = -1;
         merr = 1'b0;
      end else begin
         if (cmo_resp.ack) begin
            if (q.size() > 0) void'(q.pop_front());
            else merr = 1'b1;
         end
         if (e_req.req && cmo_resp.req_ready) begin
            q.push_back(g);
`ifdef CMO_ARB_RR_EN
            rr = (g + 1) % N;
`endif
         end
         lock_idx = (e_req.req && !cmo_resp.req_ready) ? g : -1;
      end
      #1;
   endtask

   task automatic cyc();
      settle();
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      for (int i = 0; i < N; i++) req[i].req = 1'b0;
      cmo_resp = '{req_ready: 1'b1, ack: 1'b1, trans_id: 4'd0};
      while (q.size() > 0 && n < 10) begin
         cyc();
         n++;
      end
      cmo_resp.ack = 1'b0;
   endtask

   initial begin
      req = '0;
      cmo_resp = '0;
      do_reset();

      // Reset state
      settle();
      chk("rst_resp", 128'(resp), 128'(0));
      chk("rst_req_vld", 128'(cmo_req.req), 128'(0));
      chk("rst_outst", 128'(outst), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      tick();

      // Single request, ack two cycles later
      req[0] = '{req: 1'b1, trans_id: 4'd3, address: 64'h8000_0040, cmo_op: CMO_CLEAN};
      cmo_resp.req_ready = 1'b1;
      settle();
      chk("single_req", 128'(cmo_req), {55'd0, 1'b1, 4'd3, 64'h8000_0040, 4'd0});
      tick();
      req[0].req = 1'b0;
      settle();
      chk("single_outst1", 128'(outst), 128'(1));
      tick();
      cmo_resp.ack = 1'b1;
      cmo_resp.trans_id = 4'd3;
      settle();
      chk("single_ack", 128'(resp[0].ack), 128'(1));
      chk("single_ack_tid", 128'(resp[0].trans_id), 128'(3));
      chk("single_other_ack", 128'(resp[1].ack), 128'(0));
      tick();
      cmo_resp.ack = 1'b0;
      settle();
      chk("single_outst0", 128'(outst), 128'(0));
      tick();

      // Contention between requesters 0 and 1
      do_reset();
      req[0] = '{req: 1'b1, trans_id: 4'd1, address: 64'h100, cmo_op: CMO_FLUSH};
      req[1] = '{req: 1'b1, trans_id: 4'd2, address: 64'h200, cmo_op: CMO_INV};
      cmo_resp.req_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         int ei;
`ifdef CMO_ARB_RR_EN
         ei = k % 2;
`else
         ei = 0;
`endif
         cmo_resp.ack = (k > 0);
         settle();
         chk("cont_gnt", 128'(resp[ei].req_ready), 128'(1));
         chk("cont_tid", 128'(cmo_req.trans_id), 128'(ei + 1));
         tick();
      end
      drain();

      // Lock: requester 1 stalled, requester 0 arrives
      req[1] = '{req: 1'b1, trans_id: 4'd5, address: 64'h300, cmo_op: CMO_ZERO};
      cmo_resp.req_ready = 1'b0;
      settle();
      chk("lock_first", 128'(cmo_req.trans_id), 128'(5));
      tick();
      req[0] = '{req: 1'b1, trans_id: 4'd6, address: 64'h400, cmo_op: CMO_CLEAN};
      settle();
      chk("lock_hold", 128'(cmo_req.trans_id), 128'(5));
      tick();
      cmo_resp.req_ready = 1'b1;
      settle();
      chk("lock_accept_tid", 128'(cmo_req.trans_id), 128'(5));
      chk("lock_accept_rdy1", 128'(resp[1].req_ready), 128'(1));
      chk("lock_accept_rdy0", 128'(resp[0].req_ready), 128'(0));
      tick();
      req[1].req = 1'b0;
      settle();
      chk("lock_release", 128'(cmo_req.trans_id), 128'(6));
      tick();
      drain();

      // Full FIFO
      req[0] = '{req: 1'b1, trans_id: 4'd7, address: 64'h500, cmo_op: CMO_FLUSH};
      cmo_resp.req_ready = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      cmo_resp.ack = 1'b1;
      settle();
      chk("full_outst", 128'(outst), 128'(4));
      chk("full_req_vld", 128'(cmo_req.req), 128'(0));
      for (int i = 0; i < N; i++) chk("full_rdy", 128'(resp[i].req_ready), 128'(0));
      tick();
      cmo_resp.ack = 1'b0;
      settle();
      chk("full_fifth_vld", 128'(cmo_req.req), 128'(1));
      chk("full_fifth_rdy", 128'(resp[0].req_ready), 128'(1));
      chk("full_after_ack", 128'(outst), 128'(3));
      tick();
      drain();

      // Spurious ack
      cmo_resp = '{req_ready: 1'b1, ack: 1'b1, trans_id: 4'd9};
      settle();
      chk("spur_noack", 128'(resp), 128'(0));
      tick();
      cmo_resp.ack = 1'b0;
      settle();
      chk("spur_err", 128'(err), 128'(1));
      tick();
      for (int k = 0; k < 3; k++) cyc();
      settle();
      chk("spur_err_held", 128'(err), 128'(1));
      tick();
      do_reset();
      settle();
      chk("spur_err_cleared", 128'(err), 128'(0));
      tick();

      // Random traffic with occasional mid-transaction reset
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < N; i++) begin
            req[i].req      = ($urandom_range(0, 1) == 1);
            req[i].trans_id = 4'($urandom);
            req[i].address  = {$urandom, $urandom};
            req[i].cmo_op   = cmo_t'($urandom_range(0, 3));
         end
         cmo_resp.req_ready = ($urandom_range(0, 9) < 7);
         cmo_resp.ack       = ($urandom_range(0, 9) < 4);
         cmo_resp.trans_id  = 4'($urandom);
         rst_n = ($urandom_range(0, 99) != 0);
         cyc();
      end
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
